// File: rtl/serial_alu_outq.sv
// -----------------------------------------------------------------------------
// serial_alu_outq
//   Result queue placed directly after serial_alu. Every single-cycle ALU
//   result strobe is captured into a small circular FIFO and re-presented to a
//   consumer through a valid/ready handshake. Operations issued to the ALU but
//   not yet returned are counted so that a registered credit signal can hold
//   the issuer off before the queue could overflow.
//
//   Optional feature: define SERIAL_ALU_OUTQ_SEQ_EN to add the out_seq port,
//   an 8-bit sequence tag carried with each stored entry.
//
// Ports
//   clock      in   1    sole clock, rising edge
//   resetn     in   1    synchronous active-low reset
//   issue      in   1    one pulse per operation accepted by the ALU
//   alu_dat    in   8    ALU result data
//   alu_vld    in   1    ALU result strobe
//   credit_ok  out  1    one more issue is guaranteed a FIFO slot
//   out_dat    out  8    head-of-queue data (0 when empty)
//   out_vld    out  1    queue non-empty
//   out_rdy    in   1    consumer accepts the head entry
//   level      out  LW   number of stored entries
//   ovf        out  1    sticky drop / in-flight overrun flag
//   out_seq    out  8    head sequence tag (SERIAL_ALU_OUTQ_SEQ_EN only)
// -----------------------------------------------------------------------------
module serial_alu_outq #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          issue,
  input  logic [7:0]    alu_dat,
  input  logic          alu_vld,
  output logic          credit_ok,
  output logic [7:0]    out_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [LW-1:0] level,
  output logic          ovf
`ifdef SERIAL_ALU_OUTQ_SEQ_EN
  ,
  output logic [7:0]    out_seq
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW:0]   DEPTH_X = (LW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] infl_q, infl_d;
  logic          ovf_q, ovf_d;
  logic          credit_q, credit_d;

  logic          pop;
  logic          push;
  logic          full;

`ifdef SERIAL_ALU_OUTQ_SEQ_EN
  logic [7:0]    seq_mem [DEPTH];
  logic [7:0]    seq_q, seq_d;
`endif

  // ---- event decode ---------------------------------------------------------
  always_comb begin
    full = (level_q == DEPTH_L);
    pop  = (level_q != '0) && out_rdy;
    // A pop in the same cycle frees the slot even when the queue is full.
    push = alu_vld && (!full || pop);
  end

  // ---- next-state -----------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    infl_d   = infl_q;
    ovf_d    = ovf_q;
    credit_d = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Result strobe with the queue full and no pop: data is lost.
    if (alu_vld && !push) ovf_d = 1'b1;

    case ({issue, alu_vld})
      2'b10: begin
        if (infl_q == DEPTH_L) ovf_d  = 1'b1;
        else                   infl_d = infl_q + LW'(1);
      end
      2'b01: begin
        // An unexpected return (e.g. after a mid-operation reset) saturates.
        if (infl_q != '0) infl_d = infl_q - LW'(1);
      end
      default: infl_d = infl_q;
    endcase

    // Credit is registered from next-state values, so the issuer may issue one
    // extra operation before seeing it drop; hence strict < DEPTH.
    credit_d = ({1'b0, level_d} + {1'b0, infl_d}) < DEPTH_X;
  end

  // ---- control state --------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      infl_q   <= '0;
      ovf_q    <= 1'b0;
      credit_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      infl_q   <= infl_d;
      ovf_q    <= ovf_d;
      credit_q <= credit_d;
    end
  end

  // ---- storage (not reset) --------------------------------------------------
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= alu_dat;
  end

`ifdef SERIAL_ALU_OUTQ_SEQ_EN
  always_comb begin
    seq_d = seq_q;
    // Dropped results never reach here, so they do not consume a tag.
    if (push) seq_d = seq_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) seq_q <= 8'd0;
    else         seq_q <= seq_d;
  end

  always_ff @(posedge clock) begin
    if (push) seq_mem[wr_ptr_q] <= seq_q;
  end

  assign out_seq = out_vld ? seq_mem[rd_ptr_q] : 8'h00;
`endif

  // ---- outputs: registered state only ---------------------------------------
  assign out_vld   = (level_q != '0);
  assign out_dat   = out_vld ? mem[rd_ptr_q] : 8'h00;
  assign level     = level_q;
  assign ovf       = ovf_q;
  assign credit_ok = credit_q;

endmodule

// File: tb/tb_serial_alu_outq.sv
module tb_serial_alu_outq;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          resetn;
  logic          issue;
  logic [7:0]    alu_dat;
  logic          alu_vld;
  logic          credit_ok;
  logic [7:0]    out_dat;
  logic          out_vld;
  logic          out_rdy;
  logic [LW-1:0] level;
  logic          ovf;
`ifdef SERIAL_ALU_OUTQ_SEQ_EN
  logic [7:0]    out_seq;
`endif

  int nchk = 0;
  int nerr = 0;

  serial_alu_outq #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .issue     (issue),
    .alu_dat   (alu_dat),
    .alu_vld   (alu_vld),
    .credit_ok (credit_ok),
    .out_dat   (out_dat),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .level     (level),
    .ovf       (ovf)
`ifdef SERIAL_ALU_OUTQ_SEQ_EN
    ,
    .out_seq   (out_seq)
`endif
  );

  always #5 clock = ~clock;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
      else begin
        nerr++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    alu_vld = 1'b1;
    alu_dat = d;
    tick();
    alu_vld = 1'b0;
    alu_dat = 8'h00;
  endtask

  task automatic pop();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
  endtask

  task automatic do_issue();
    issue = 1'b1;
    tick();
    issue = 1'b0;
  endtask

  initial begin
    issue   = 1'b0;
    alu_dat = 8'h00;
    alu_vld = 1'b0;
    out_rdy = 1'b0;
    resetn  = 1'b0;
    #2;

    // Reset values
    do_reset();
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_credit", 32'(credit_ok), 32'd1);
    chk("rst_out_dat", 32'(out_dat), 32'h00);

    // out_rdy on an empty queue does nothing
    pop();
    chk("empty_pop_level", 32'(level), 32'd0);
    chk("empty_pop_vld", 32'(out_vld), 32'd0);

    // Single result: issue at cycle 0, return at cycle 9
    do_issue();
    chk("single_credit_after_issue", 32'(credit_ok), 32'd1);
    for (int i = 0; i < 8; i++) tick();
    chk("single_vld_before", 32'(out_vld), 32'd0);
    push(8'h5A);
    chk("single_vld", 32'(out_vld), 32'd1);
    chk("single_dat", 32'(out_dat), 32'h5A);
    chk("single_level", 32'(level), 32'd1);
    chk("single_credit", 32'(credit_ok), 32'd1);
    tick();
    chk("single_hold_dat", 32'(out_dat), 32'h5A);
    pop();
    chk("single_pop_level", 32'(level), 32'd0);
    chk("single_pop_dat", 32'(out_dat), 32'h00);

    // Fill and drop
    do_reset();
    for (int i = 1; i <= 4; i++) push(8'(i));
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_credit", 32'(credit_ok), 32'd0);
    chk("fill_ovf_before", 32'(ovf), 32'd0);
    push(8'h05);
    chk("drop_level", 32'(level), 32'd4);
    chk("drop_ovf", 32'(ovf), 32'd1);
    chk("drop_head", 32'(out_dat), 32'h01);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain_%0d", i), 32'(out_dat), 32'(i));
      pop();
    end
    chk("drain_vld", 32'(out_vld), 32'd0);
    chk("drain_ovf_sticky", 32'(ovf), 32'd1);
    chk("drain_credit", 32'(credit_ok), 32'd1);

    // Full with simultaneous push and pop
    do_reset();
    chk("reset_clears_ovf", 32'(ovf), 32'd0);
    for (int i = 1; i <= 4; i++) push(8'(i));
    out_rdy = 1'b1;
    push(8'hAA);
    out_rdy = 1'b0;
    chk("fullpp_level", 32'(level), 32'd4);
    chk("fullpp_ovf", 32'(ovf), 32'd0);
    chk("fullpp_head", 32'(out_dat), 32'h02);
    chk("fullpp_d0", 32'(out_dat), 32'h02); pop();
    chk("fullpp_d1", 32'(out_dat), 32'h03); pop();
    chk("fullpp_d2", 32'(out_dat), 32'h04); pop();
    chk("fullpp_d3", 32'(out_dat), 32'hAA); pop();
    chk("fullpp_empty", 32'(out_vld), 32'd0);

    // Credit accounting
    do_reset();
    push(8'h11);
    do_issue();
    chk("credit_i1", 32'(credit_ok), 32'd1);
    do_issue();
    chk("credit_i2", 32'(credit_ok), 32'd1);
    do_issue();
    chk("credit_i3", 32'(credit_ok), 32'd0);
    out_rdy = 1'b1;
    push(8'h77);
    out_rdy = 1'b0;
    chk("credit_ret", 32'(credit_ok), 32'd1);
    chk("credit_ret_level", 32'(level), 32'd1);
    chk("credit_ret_dat", 32'(out_dat), 32'h77);

    // Return with nothing in flight: counter must not underflow
    do_reset();
    push(8'h33);
    chk("unexp_level", 32'(level), 32'd1);
    chk("unexp_dat", 32'(out_dat), 32'h33);
    chk("unexp_credit", 32'(credit_ok), 32'd1);
    do_issue();
    do_issue();
    chk("unexp_credit_2", 32'(credit_ok), 32'd1);
    do_issue();
    chk("unexp_credit_3", 32'(credit_ok), 32'd0);
    chk("unexp_ovf", 32'(ovf), 32'd0);

    // In-flight overrun
    do_reset();
    for (int i = 0; i < 4; i++) do_issue();
    chk("infl_full_ovf", 32'(ovf), 32'd0);
    chk("infl_full_credit", 32'(credit_ok), 32'd0);
    do_issue();
    chk("infl_overrun_ovf", 32'(ovf), 32'd1);
    // Simultaneous issue and return at DEPTH leaves the count alone
    do_reset();
    for (int i = 0; i < 4; i++) do_issue();
    issue = 1'b1;
    push(8'h44);
    issue = 1'b0;
    chk("infl_both_ovf", 32'(ovf), 32'd0);
    chk("infl_both_level", 32'(level), 32'd1);
    chk("infl_both_credit", 32'(credit_ok), 32'd0);

`ifdef SERIAL_ALU_OUTQ_SEQ_EN
    // Sequence tags with continuous draining
    do_reset();
    chk("seq_empty", 32'(out_seq), 32'd0);
    out_rdy = 1'b1;
    for (int k = 0; k < 260; k++) begin
      alu_vld = 1'b1;
      alu_dat = 8'(k) ^ 8'h3C;
      tick();
      chk($sformatf("seq_tag_%0d", k), 32'(out_seq), 32'(k & 255));
      chk($sformatf("seq_dat_%0d", k), 32'(out_dat), 32'((k & 255) ^ 8'h3C));
    end
    alu_vld = 1'b0;
    tick();
    out_rdy = 1'b0;
    chk("seq_end_vld", 32'(out_vld), 32'd0);
    chk("seq_end_tag", 32'(out_seq), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
